// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the memory bus arbiter: default widths, the main
// sequencer and write-buffer state encodings, and the read grant ids.
package mem_bus_arb_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_LINE_W = 1024;
  localparam int DEF_OFFS_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DV   = 2'd3
  } main_st_t;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ADDR  = 2'd1,
    WB_FULL  = 2'd2
  } wb_st_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_bus_arb_if.sv
// Bundle of the cache-side and memory-side signals of the arbiter.
// master: the arbiter's view. slave: the surrounding caches/memory view.
interface mem_bus_arb_if #(
  parameter int ADDR_W = mem_bus_arb_pkg::DEF_ADDR_W,
  parameter int LINE_W = mem_bus_arb_pkg::DEF_LINE_W
);
  import mem_bus_arb_pkg::*;

  logic [ADDR_W-1:0] i_addr;
  logic              i_rd;
  logic              i_dv;
  logic [LINE_W-1:0] i_data;
  logic [ADDR_W-1:0] d_addr;
  logic              d_rd;
  logic              d_dv;
  logic [LINE_W-1:0] d_data;
  logic              d_wr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_wr_busy;
  logic [ADDR_W-1:0] m_addr;
  logic              m_rd;
  logic              m_wr;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_ack;

  modport master (
    input  i_addr, i_rd, d_addr, d_rd, d_wr, d_wdata, m_rdata, m_ack,
    output i_dv, i_data, d_dv, d_data, d_wr_busy, m_addr, m_rd, m_wr, m_wdata
  );

  modport slave (
    output i_addr, i_rd, d_addr, d_rd, d_wr, d_wdata, m_rdata, m_ack,
    input  i_dv, i_data, d_dv, d_data, d_wr_busy, m_addr, m_rd, m_wr, m_wdata
  );

endinterface

// File: rtl/mem_bus_arb_wbuf.sv
// Single-entry posted write-through buffer. Address is captured with the
// strobe, data one cycle later; the entry is released by the drain ack.
module mem_bus_arb_wbuf
  import mem_bus_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int OFFS_W = DEF_OFFS_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              i_cap,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic              i_drain_ack,
  output logic              o_full,
  output logic              o_pend,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_addr,
  output logic [LINE_W-1:0] o_data
);

  localparam logic [ADDR_W-1:0] LP_LINE_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

  wb_st_t            r_state;
  logic              r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_data;

  // Buffer state machine: capture address, then data, hold until drained.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= WB_EMPTY;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        WB_EMPTY: begin
          if (i_cap) begin
            r_addr  <= i_addr & LP_LINE_MASK;
            r_busy  <= 1'b1;
            r_state <= WB_ADDR;
          end else begin
            r_state <= WB_EMPTY;
          end
        end
        WB_ADDR: begin
          r_data  <= i_wdata;
          r_state <= WB_FULL;
        end
        WB_FULL: begin
          if (i_drain_ack) begin
            r_busy  <= 1'b0;
            r_state <= WB_EMPTY;
          end else begin
            r_state <= WB_FULL;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= WB_EMPTY;
        end
      endcase
    end
  end

  assign o_full = (r_state == WB_FULL);
  assign o_pend = (r_state == WB_ADDR);
  assign o_busy = r_busy;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/mem_bus_arb.sv
// Memory bus arbiter between the icache (reads) and dcache (reads plus
// posted write-through). A full write buffer drains before any read; a
// half-captured write stalls reads to keep read-after-write ordering.
// Optional macro MEM_BUS_ARB_RR_EN: round-robin between i_rd and d_rd
// (otherwise d_rd has fixed priority over i_rd).
module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int OFFS_W = DEF_OFFS_W
) (
  input  logic          clk,
  input  logic          clr_n,
  mem_bus_arb_if.master bus
);

  localparam logic [ADDR_W-1:0] LP_LINE_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

  main_st_t          r_st;
  gnt_t              r_gnt;
  gnt_t              w_gnt;
  logic              w_wb_full;
  logic              w_wb_pend;
  logic              w_wb_busy;
  logic [ADDR_W-1:0] w_wb_addr;
  logic [LINE_W-1:0] w_wb_data;
  logic              w_drain_ack;

  assign w_drain_ack   = (r_st == ST_WR) && bus.m_ack;
  assign bus.d_wr_busy = w_wb_busy;

  mem_bus_arb_wbuf #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .OFFS_W (OFFS_W)
  ) u_wbuf (
    .clk         (clk),
    .clr_n       (clr_n),
    .i_cap       (bus.d_wr),
    .i_addr      (bus.d_addr),
    .i_wdata     (bus.d_wdata),
    .i_drain_ack (w_drain_ack),
    .o_full      (w_wb_full),
    .o_pend      (w_wb_pend),
    .o_busy      (w_wb_busy),
    .o_addr      (w_wb_addr),
    .o_data      (w_wb_data)
  );

`ifdef MEM_BUS_ARB_RR_EN
  gnt_t r_last_gnt;
  logic w_rd_grant;

  assign w_rd_grant = (r_st == ST_IDLE) && !w_wb_full && !w_wb_pend && (bus.i_rd || bus.d_rd);

  // Remember the most recent read grant so a tie goes to the other side.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_last_gnt <= GNT_D;
    end else if (w_rd_grant) begin
      r_last_gnt <= w_gnt;
    end else begin
      r_last_gnt <= r_last_gnt;
    end
  end
`endif

  // Pick the read requester: round-robin on a tie, or fixed dcache priority.
  always_comb begin
    w_gnt = GNT_I;
`ifdef MEM_BUS_ARB_RR_EN
    if (bus.i_rd && bus.d_rd) begin
      if (r_last_gnt == GNT_D) begin
        w_gnt = GNT_I;
      end else begin
        w_gnt = GNT_D;
      end
    end else if (bus.d_rd) begin
      w_gnt = GNT_D;
    end else begin
      w_gnt = GNT_I;
    end
`else
    if (bus.d_rd) begin
      w_gnt = GNT_D;
    end else begin
      w_gnt = GNT_I;
    end
`endif
  end

  // Main sequencer: drain writes, run reads, pulse fill-valid with registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_st        <= ST_IDLE;
      r_gnt       <= GNT_D;
      bus.m_rd    <= 1'b0;
      bus.m_wr    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.i_dv    <= 1'b0;
      bus.d_dv    <= 1'b0;
      bus.i_data  <= '0;
      bus.d_data  <= '0;
    end else begin
      bus.i_dv <= 1'b0;
      bus.d_dv <= 1'b0;
      case (r_st)
        ST_IDLE: begin
          if (w_wb_full) begin
            bus.m_wr    <= 1'b1;
            bus.m_addr  <= w_wb_addr;
            bus.m_wdata <= w_wb_data;
            r_st        <= ST_WR;
          end else if (w_wb_pend) begin
            r_st <= ST_IDLE;
          end else if (bus.i_rd || bus.d_rd) begin
            bus.m_rd   <= 1'b1;
            bus.m_addr <= ((w_gnt == GNT_D) ? bus.d_addr : bus.i_addr) & LP_LINE_MASK;
            r_gnt      <= w_gnt;
            r_st       <= ST_RD;
          end else begin
            r_st <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (bus.m_ack) begin
            bus.m_rd <= 1'b0;
            if (r_gnt == GNT_D) begin
              bus.d_data <= bus.m_rdata;
              bus.d_dv   <= 1'b1;
            end else begin
              bus.i_data <= bus.m_rdata;
              bus.i_dv   <= 1'b1;
            end
            r_st <= ST_DV;
          end else begin
            r_st <= ST_RD;
          end
        end
        ST_WR: begin
          if (bus.m_ack) begin
            bus.m_wr <= 1'b0;
            r_st     <= ST_IDLE;
          end else begin
            r_st <= ST_WR;
          end
        end
        ST_DV: begin
          r_st <= ST_IDLE;
        end
        default: begin
          bus.m_rd <= 1'b0;
          bus.m_wr <= 1'b0;
          r_st     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arb.md
Name: mem_bus_arb

Overview:
- Arbitrates the single external line-wide memory port between the instruction cache (read-only) and the data cache (read and write-through).
- Holds one posted write-through entry from the data cache.
- Sequences read and write transactions on the memory side and returns fill data with a one-cycle valid pulse.
- Sits between both caches and the memory/bus interface.

Parameters:
ADDR_W, 64, address width
LINE_W, 1024, cache line width in bits
OFFS_W, 7, line offset bits cleared on the memory address (log2(LINE_W/8))

Ports:
clk  in  1  clock
clr_n  in  1  asynchronous active-low reset
i_addr  in  ADDR_W  icache miss address
i_rd  in  1  icache line read request (level)
i_dv  out  1  icache fill data valid, one-cycle pulse
i_data  out  LINE_W  icache fill data
d_addr  in  ADDR_W  dcache address
d_rd  in  1  dcache line read request (level)
d_dv  out  1  dcache fill data valid, one-cycle pulse
d_data  out  LINE_W  dcache fill data
d_wr  in  1  dcache write-through strobe
d_wdata  in  LINE_W  dcache write-through line; valid the cycle after d_wr
d_wr_busy  out  1  write buffer not empty
m_addr  out  ADDR_W  memory address, low OFFS_W bits zero
m_rd  out  1  memory read request, held until m_ack
m_wr  out  1  memory write request, held until m_ack
m_wdata  out  LINE_W  memory write data
m_rdata  in  LINE_W  memory read data, valid with m_ack
m_ack  in  1  memory completion, one-cycle pulse

Behaviour:
- Reset (clr_n low, async): all outputs 0; main FSM IDLE; write buffer EMPTY; last_grant=D.
- Write buffer FSM, states EMPTY, ADDR, FULL:
  - EMPTY + d_wr: latch d_addr (offset cleared), go to ADDR; d_wr_busy=1 from the next cycle.
  - ADDR: latch d_wdata, go to FULL.
  - FULL: drained by the main FSM; returns to EMPTY on the m_ack of the write.
  - d_wr while not EMPTY: ignored (dropped). The dcache must not issue it.
- Main FSM, states IDLE, RD, WR, DV:
  - IDLE, priority order:
    1. Buffer FULL: go to WR.
    2. Buffer ADDR: stall, no grant (read-after-write ordering).
    3. d_rd/i_rd: grant per arbitration, go to RD. Latch the requester's address and the grant id.
  - RD: m_rd=1 and m_addr stable until m_ack. On m_ack: latch m_rdata into the granted requester's data register, go to DV.
  - WR: m_wr=1, m_addr and m_wdata from the buffer. On m_ack: go to IDLE and empty the buffer; d_wr_busy falls the next cycle.
  - DV: assert the granted requester's dv for exactly one cycle; go to IDLE.
  - The requester drops rd by the cycle after DV, so no re-grant is possible.
- Latency:
  - Request seen in IDLE at cycle N gives m_rd at N+1.
  - m_ack at cycle K gives dv at K+1.
  - Minimum read round trip is 3 cycles.
- Data registers hold their value after DV until the next fill for that requester.
- m_ack outside RD/WR is ignored.
- A request dropped mid-transaction does not abort it; the transaction completes and dv is still pulsed.
- m_addr = {addr[ADDR_W-1:OFFS_W], OFFS_W zeros}.
- Reset mid-transaction: immediate abort, buffer contents lost, no dv emitted, a late m_ack ignored.

Optional Feature:
- Macro: MEM_BUS_ARB_RR_EN.
- Defined: round-robin between i_rd and d_rd. On a tie, grant the requester not in last_grant; last_grant updates on each read grant.
- Undefined: fixed priority, d_rd over i_rd; last_grant is not implemented.
- Write-buffer drain precedes reads in both cases.

Decomposition:
- Shared header mem_bus_defs.vh:
  - main FSM encodings (IDLE, RD, WR, DV)
  - write buffer encodings (EMPTY, ADDR, FULL)
  - grant ids (GNT_I, GNT_D)
  - default widths
- Sub-module mem_bus_wbuf: the single-entry write buffer and its FSM. Interface: capture strobe, full/busy, drain-ack input, addr/data outputs.

Test Plan:
1. i_rd=1, i_addr=0x1234, m_ack 3 cycles after m_rd with m_rdata=pattern P -> m_rd rises 1 cycle after i_rd; m_addr=0x1200; i_dv one cycle after m_ack; i_data=P; d_dv stays 0.
2. i_rd and d_rd rise together after reset -> without MEM_BUS_ARB_RR_EN, d_addr is served first; with the macro defined, i_addr is served first then d_addr. Each requester gets exactly one dv.
3. d_wr with d_addr=0x1000, d_wdata=0xA5 repeated next cycle -> d_wr_busy=1; m_wr with m_addr=0x1000 and m_wdata=0xA5 repeated; d_wr_busy=0 one cycle after m_ack.
4. d_wr to 0x2000 followed immediately by d_rd to 0x2000 -> m_wr completes (m_ack) before m_rd asserts; d_dv follows the read's m_ack.
5. Second d_wr while d_wr_busy=1 -> dropped; only one m_wr transaction is observed.
6. clr_n pulsed low while m_rd=1, then m_ack arrives -> all outputs 0 during reset; no i_dv/d_dv; FSM idle; next request is served normally.
